// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: I2C master write sequencer (START, addr+W, ACK, data, ACK, STOP) driving an external bit counter
module i2c_write_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [6:0]  slave_addr,
  input  logic [7:0]  wr_data,
  input  logic [31:0] EightBitCount,
  output logic        LoadEightBitCount,
  output logic        DecEightBitCount,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        busy,
  output logic        done,
  output logic        ack_error
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [1:0] q;
  logic [7:0] shreg, data_q;
  logic ack_smp, tick, q3t, is_ack, is_bit;
  assign tick = state != IDLE && div == DW'(CLK_DIV - 1);
  assign q3t = tick && q == 2'd3;
  assign is_ack = state == ADDR_ACK || state == DATA_ACK;
  assign is_bit = state == ADDR || state == DATA;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    LoadEightBitCount = 1'b0;
    DecEightBitCount = 1'b0;
    scl = 1'b1;
    sda_oe = 1'b0;
    case (state)
      IDLE: state_nx = start ? START : IDLE;
      START: begin
        sda_oe = q[1];
        if (q3t) begin
          state_nx = ADDR;
          LoadEightBitCount = 1'b1;
        end
      end
      ADDR, DATA: begin
        scl = q[1];
        sda_oe = ~shreg[7];
        if (q3t) begin
          DecEightBitCount = 1'b1;
          if (EightBitCount == 32'd1) state_nx = state == ADDR ? ADDR_ACK : DATA_ACK;
        end
      end
      ADDR_ACK, DATA_ACK: begin
        scl = q[1];
        if (q3t) begin
          state_nx = (ack_smp || state == DATA_ACK) ? STOP : DATA;
          LoadEightBitCount = !ack_smp && state == ADDR_ACK;
        end
      end
      STOP: begin
        scl = q[1];
        sda_oe = q != 2'd3;
        if (q3t) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      div <= '0;
      q <= '0;
      shreg <= '0;
      data_q <= '0;
      ack_smp <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      state <= state_nx;
      div <= (state == IDLE || tick) ? '0 : div + 1'b1;
      q <= state == IDLE ? 2'd0 : q + {1'b0, tick};
      ack_smp <= (is_ack && tick && q == 2'd2) ? sda_in : ack_smp;
      if (state == IDLE && start) begin
        shreg <= {slave_addr, 1'b0};
        data_q <= wr_data;
        ack_error <= 1'b0;
      end else if (is_bit && q3t) begin
        shreg <= {shreg[6:0], 1'b0};
      end else if (state == ADDR_ACK && q3t && !ack_smp) begin
        shreg <= data_q;
      end
      if (is_ack && q3t && ack_smp) ack_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb_i2c_write_sequencer: vector-table bench with bit-counter and slave models on two divider settings
module tb_i2c_write_sequencer;
  logic clk, rst;
  logic [1:0] start, scl, oe, sin, busy, done, aerr, ld, dc, line, pull, scl_p, line_p, na, nd;
  logic [6:0] addr [2];
  logic [7:0] wd [2];
  logic [31:0] cnt [2];
  logic [31:0] bits [2];
  int acc [2], lat [2], n_ld [2], n_dc [2], n_rise [2], n_sta [2], n_sto [2], n_done [2], n_both [2], f [2];
  int cyc = 0, nvec = 0, nerr = 0;

  typedef struct {
    int g;
    logic [6:0] a;
    logic [7:0] d;
    logic na, nd;
    int lat, nld, ndc;
    logic aerr;
    int nrise;
    logic [31:0] bits;
  } vec_t;
  vec_t vec [9];

  for (genvar g = 0; g < 2; g++) begin : u
    i2c_write_sequencer #(.CLK_DIV(g == 0 ? 2 : 1)) dut (
      .clk(clk), .Reset(rst), .start(start[g]), .slave_addr(addr[g]), .wr_data(wd[g]),
      .EightBitCount(cnt[g]), .LoadEightBitCount(ld[g]), .DecEightBitCount(dc[g]),
      .scl(scl[g]), .sda_oe(oe[g]), .sda_in(sin[g]), .busy(busy[g]), .done(done[g]),
      .ack_error(aerr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave pulls SDA for the ACK bit once the 9th / 18th SCL fall has been seen
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      pull[g] = (f[g] == 9 && !na[g]) || (f[g] == 18 && !nd[g]);
      line[g] = ~oe[g] & ~pull[g];
      sin[g] = line[g];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      cnt[g] <= rst ? 32'd0 : ld[g] ? 32'd8 : dc[g] ? cnt[g] - 32'd1 : cnt[g];
      scl_p[g] <= scl[g];
      line_p[g] <= line[g];
      if (!rst && start[g] && !busy[g]) begin
        acc[g] <= cyc; lat[g] <= 0; n_ld[g] <= 0; n_dc[g] <= 0; n_rise[g] <= 0;
        n_sta[g] <= 0; n_sto[g] <= 0; n_done[g] <= 0; n_both[g] <= 0; f[g] <= 0; bits[g] <= 0;
      end else begin
        n_ld[g] <= n_ld[g] + int'(ld[g]);
        n_dc[g] <= n_dc[g] + int'(dc[g]);
        n_both[g] <= n_both[g] + int'(ld[g] & dc[g]);
        if (scl[g] && !scl_p[g]) begin
          bits[g] <= {bits[g][30:0], line[g]};
          n_rise[g] <= n_rise[g] + 1;
        end
        if (!scl[g] && scl_p[g]) f[g] <= f[g] + 1;
        if (scl[g] && scl_p[g] && line_p[g] && !line[g]) n_sta[g] <= n_sta[g] + 1;
        if (scl[g] && scl_p[g] && !line_p[g] && line[g]) n_sto[g] <= n_sto[g] + 1;
        if (done[g]) begin
          lat[g] <= cyc - acc[g];
          n_done[g] <= n_done[g] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic go(input int g, input logic [6:0] a, input logic [7:0] d);
    addr[g] = a;
    wd[g] = d;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    chk("busy_on", 32'(busy[g]), 1);
    chk("aerr_clr", 32'(aerr[g]), 0);
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    while (!done[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done[g]), 1);
  endtask

  task automatic post(input int g, input vec_t v);
    chk("busy_off", 32'(busy[g]), 0);
    chk("aerr_held", 32'(aerr[g]), 32'(v.aerr));
    chk("latency", lat[g], v.lat);
    chk("loads", n_ld[g], v.nld);
    chk("decs", n_dc[g], v.ndc);
    chk("scl_rises", n_rise[g], v.nrise);
    chk("sda_bits", bits[g], v.bits);
    chk("starts", n_sta[g], 1);
    chk("stops", n_sto[g], 1);
    chk("done_pulses", n_done[g], 1);
    chk("strobe_overlap", n_both[g], 0);
  endtask

  task automatic apply(input vec_t v);
    na[v.g] = v.na;
    nd[v.g] = v.nd;
    go(v.g, v.a, v.d);
    wait_done(v.g);
    chk("aerr_at_done", 32'(aerr[v.g]), 32'(v.aerr));
    repeat (2) @(negedge clk);
    post(v.g, v);
  endtask

  initial begin
    vec[0] = '{0, 7'h50, 8'hA5, 1'b0, 1'b0, 161, 2, 16, 1'b0, 19, 32'({8'hA0, 1'b0, 8'hA5, 2'b00})};
    vec[1] = '{0, 7'h50, 8'hA5, 1'b1, 1'b0, 89, 1, 8, 1'b1, 10, 32'({8'hA0, 2'b10})};
    vec[2] = '{0, 7'h50, 8'hA5, 1'b0, 1'b1, 161, 2, 16, 1'b1, 19, 32'({8'hA0, 1'b0, 8'hA5, 2'b10})};
    vec[3] = '{0, 7'h7F, 8'hFF, 1'b0, 1'b0, 161, 2, 16, 1'b0, 19, 32'({8'hFE, 1'b0, 8'hFF, 2'b00})};
    vec[4] = '{0, 7'h00, 8'h00, 1'b0, 1'b0, 161, 2, 16, 1'b0, 19, 32'd0};
    vec[5] = '{1, 7'h50, 8'hA5, 1'b0, 1'b0, 81, 2, 16, 1'b0, 19, 32'({8'hA0, 1'b0, 8'hA5, 2'b00})};
    vec[6] = '{1, 7'h3C, 8'h0F, 1'b0, 1'b0, 81, 2, 16, 1'b0, 19, 32'({8'h78, 1'b0, 8'h0F, 2'b00})};
    vec[7] = '{1, 7'h50, 8'hA5, 1'b1, 1'b0, 45, 1, 8, 1'b1, 10, 32'({8'hA0, 2'b10})};
    vec[8] = '{1, 7'h50, 8'hA5, 1'b0, 1'b1, 81, 2, 16, 1'b1, 19, 32'({8'hA0, 1'b0, 8'hA5, 2'b10})};
    rst = 1'b1;
    start = '0;
    na = '0;
    nd = '0;
    for (int g = 0; g < 2; g++) begin
      addr[g] = '0;
      wd[g] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'b11);
    chk("rst_oe", 32'(oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aerr", 32'(aerr), 0);
    chk("rst_strobes", 32'({ld, dc}), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) apply(vec[i]);
    // start while busy and during DONE must be ignored
    na[1] = 1'b0;
    nd[1] = 1'b0;
    go(1, 7'h50, 8'hA5);
    repeat (30) @(negedge clk);
    addr[1] = 7'h11;
    wd[1] = 8'h22;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (10) @(negedge clk);
    post(1, vec[5]);
    // reset in the middle of the data byte, then a clean transaction
    na[0] = 1'b0;
    nd[0] = 1'b0;
    go(0, 7'h50, 8'hA5);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_scl", 32'(scl[0]), 1);
    chk("mid_rst_oe", 32'(oe[0]), 0);
    chk("mid_rst_busy", 32'(busy[0]), 0);
    chk("mid_rst_done", 32'(done[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    apply(vec[0]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
- Bit/byte-level master sequencer for the I2C write transaction.
- Generates START, the address byte (7-bit address + W=0), ACK slot, data byte, ACK slot and STOP on SCL/SDA.
- Sits directly upstream of the eight-bit bit counter: drives its load/decrement strobes and consumes its 32-bit count to decide end of byte.
- Bit data is shifted MSB first from an internal shift register.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; legal range ≥1; one SCL bit = 4*CLK_DIV clocks.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request a write transaction; sampled only in IDLE.
- slave_addr  in  7  target address, latched on accept.
- wr_data  in  8  data byte, latched on accept.
- EightBitCount  in  32  current value from the bit counter.
- LoadEightBitCount  out  1  one-cycle strobe: counter loads 8.
- DecEightBitCount  out  1  one-cycle strobe: counter decrements.
- scl  out  1  SCL level, push-pull, no clock stretching.
- sda_oe  out  1  1 = pull SDA low, 0 = release (open-drain).
- sda_in  in  1  SDA line level.
- busy  out  1  high from accept through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- ack_error  out  1  NACK seen; valid with done, held until next accept.

Behaviour:
- Reset (synchronous): state=IDLE, scl=1, sda_oe=0, busy=0, done=0, ack_error=0, both strobes 0, divider=0. Reset mid-transaction abandons the bus immediately (lines released, no STOP).
- Divider: counts 0..CLK_DIV-1 while not IDLE; tick when count==CLK_DIV-1. Cleared on accept; first tick CLK_DIV clocks after the accepting edge. Quarter index q (0..3) advances on each tick.
- IDLE: scl=1, sda_oe=0. If start=1, accept:
  - latch shreg={slave_addr,1'b0} and wr_data;
  - clear ack_error, set busy;
  - go to START.
  - start while not IDLE is ignored.
- START (4 quarters):
  - q0–q1: scl=1, sda_oe=0.
  - q2–q3: scl=1, sda_oe=1.
  - On the q3 tick: go to ADDR and pulse LoadEightBitCount for that one cycle.
- ADDR/DATA bit (4 quarters per bit):
  - q0–q1: scl=0, sda_oe=~shreg[7].
  - q2–q3: scl=1, SDA held.
  - On the q3 tick: pulse DecEightBitCount and shift shreg left by 1.
  - If EightBitCount==1 (full 32-bit compare) at that tick, the byte is complete: go to ADDR_ACK/DATA_ACK.
- ADDR_ACK/DATA_ACK (4 quarters):
  - sda_oe=0 throughout; scl=0 for q0–q1, scl=1 for q2–q3.
  - Sample sda_in on the q2 tick.
  - At the q3 tick, if the sample was 1: set ack_error and go to STOP.
  - If the sample was 0: ADDR_ACK goes to DATA (shreg<=wr_data, LoadEightBitCount pulse); DATA_ACK goes to STOP.
- STOP (4 quarters):
  - q0–q1: scl=0, sda_oe=1.
  - q2: scl=1, sda_oe=1.
  - q3: scl=1, sda_oe=0.
  - On the q3 tick: go to DONE.
- DONE (1 cycle): done=1, busy=1, scl=1, sda_oe=0. Next cycle goes to IDLE with busy=0.
- SDA changes only while scl=0, except START and STOP edges.
- Load-to-first-decrement spacing is ≥4 clocks, so the counter's one-cycle load latency is always absorbed.
- Strobes are never asserted simultaneously.
- Transaction length:
  - Success: 80 ticks; done high in the cycle after the edge at 80*CLK_DIV clocks from accept.
  - Address NACK: 44 ticks.

Test Plan:
- CLK_DIV=2, addr=0x50, data=0xA5, slave ACKs both bytes (sda_in=0 in ACK slots) -> SDA bits at SCL high: 1010_0000 then 1010_0101; done at 160+1 clocks; ack_error=0; exactly 2 load and 16 decrement strobes.
- Same, sda_in=1 during the address ACK -> no data byte, STOP follows directly, done after 88+1 clocks, ack_error=1, 1 load and 8 decrement strobes.
- Data-byte NACK -> ack_error=1 after a full 80-tick sequence; ack_error cleared on the next accepted start.
- start pulsed while busy and during the DONE cycle -> ignored; no second transaction, latched addr/data unchanged.
- Reset asserted mid data byte -> next cycle scl=1, sda_oe=0, busy=0, done=0; new start then runs a complete correct transaction.
- CLK_DIV=1 -> bit counter still decrements correctly (the load at the byte's first clock has settled before the first decrement); waveform identical in ticks.
